// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The master side launches DIV/DIVU operations; the slave side returns {remainder, quotient}.
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle over 32 iterations,
// returning {remainder, quotient} with the result held until the requester drops start.
module div_unit (
  input logic   clk,
  input logic   rst,
  div_if.slave  bus
);

  typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_e;

  state_e      state_q, state_d;
  logic [64:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        signed_q, signed_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_abs, op2_abs;
  logic [32:0] diff;
  logic [64:0] step;
  logic [31:0] quot_fix, rem_fix;

  // Magnitudes for signed operands; 0x80000000 maps onto itself, which is the right unsigned value.
  assign op1_abs = (bus.signed_div_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;

  // Trial subtraction of the divisor from the current partial remainder window.
  assign diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
  assign step = diff[32] ? (dividend_q << 1) : {diff[31:0], dividend_q[31:0], 1'b1};

  // Sign restoration: quotient negative on differing signs, remainder follows the dividend.
  assign quot_fix = (signed_q && (neg1_q ^ neg2_q)) ? -step[31:0]  : step[31:0];
  assign rem_fix  = (signed_q && neg1_q)            ? -step[64:33] : step[64:33];

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      ST_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == 32'd0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d    = ST_ON;
            signed_d   = bus.signed_div_i;
            neg1_d     = bus.opdata1_i[31];
            neg2_d     = bus.opdata2_i[31];
            divisor_d  = op2_abs;
            dividend_d = {32'd0, op1_abs, 1'b0};
            cnt_d      = '0;
          end
        end
      end

      ST_BYZERO: begin
        state_d  = ST_END;
        result_d = '0;
        ready_d  = 1'b1;
      end

      ST_ON: begin
        if (bus.annul_i) begin
          state_d  = ST_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          dividend_d = step;
          cnt_d      = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = ST_END;
            result_d = {rem_fix, quot_fix};
            ready_d  = 1'b1;
          end
        end
      end

      ST_END: begin
        if (!bus.start_i) begin
          state_d  = ST_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FREE;
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
